soc_tcdm_rr_xbar: RTL

Parametrised TCDM crossbar that connects NR_MASTERS TCDM masters to NR_SLAVES TCDM slaves. Each request is routed by a runtime address-rule table. Each slave has its own round-robin arbiter. Accesses that match no rule complete against an internal error responder, and a saturating counter records them. It replaces the fixed-port SoC TCDM routing stage and is used as a building block inside the SoC interconnect wrapper.

---
 rtl/soc_tcdm_rr_xbar.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/soc_tcdm_rr_xbar.sv
// TCDM crossbar: NR_MASTERS masters to NR_SLAVES slaves through a runtime
// address-rule table. Each slave has its own round-robin arbiter. Unmapped
// accesses are answered by an internal error responder and counted.

// Per-slave round-robin arbiter: picks the first candidate at or after rr_q.
module soc_tcdm_rr_xbar_arb #(
  parameter int NR_MASTERS = 4,
  parameter int MW         = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NR_MASTERS-1:0] cand_i,
  input  logic                  gnt_i,
  output logic                  req_o,
  output logic [MW-1:0]         win_o
);

  logic [MW-1:0] rr_q, rr_d;

  // Scan from the highest offset down so the smallest offset from rr_q wins.
  always_comb begin
    int j;
    req_o = 1'b0;
    win_o = '0;
    j     = 0;
    for (int i = NR_MASTERS-1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NR_MASTERS) j = j - NR_MASTERS;
      if (cand_i[j]) begin
        req_o = 1'b1;
        win_o = MW'(j);
      end
    end
  end

  // Advance past the winner only on an accepted handshake. With a single
  // master the wrap makes rr_d always 0, so rr_q stays at its reset value.
  always_comb begin
    rr_d = rr_q;
    if (req_o && gnt_i) begin
      if (int'(win_o) == NR_MASTERS-1) rr_d = '0;
      else                             rr_d = win_o + MW'(1);
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

module soc_tcdm_rr_xbar #(
  parameter int          NR_MASTERS    = 4,
  parameter int          NR_SLAVES     = 3,
  parameter int          NR_RULES      = 3,
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [31:0] ERR_DATA      = 32'hBADACCE5,
  parameter int          ERR_CNT_WIDTH = 16,
  localparam int         BE_WIDTH      = DATA_WIDTH/8,
  localparam int         IDX_WIDTH     = ($clog2(NR_SLAVES+1) > 1) ? $clog2(NR_SLAVES+1) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_RULES*ADDR_WIDTH-1:0]   rule_start_i,
  input  logic [NR_RULES*ADDR_WIDTH-1:0]   rule_end_i,
  input  logic [NR_RULES*IDX_WIDTH-1:0]    rule_idx_i,
  input  logic [NR_MASTERS-1:0]            m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0] m_add_i,
  input  logic [NR_MASTERS-1:0]            m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NR_MASTERS*BE_WIDTH-1:0]   m_be_i,
  output logic [NR_MASTERS-1:0]            m_gnt_o,
  output logic [NR_MASTERS-1:0]            m_r_valid_o,
  output logic [NR_MASTERS*DATA_WIDTH-1:0] m_r_rdata_o,
  output logic [NR_MASTERS-1:0]            m_r_opc_o,
  output logic [NR_SLAVES-1:0]             s_req_o,
  output logic [NR_SLAVES*ADDR_WIDTH-1:0]  s_add_o,
  output logic [NR_SLAVES-1:0]             s_wen_o,
  output logic [NR_SLAVES*DATA_WIDTH-1:0]  s_wdata_o,
  output logic [NR_SLAVES*BE_WIDTH-1:0]    s_be_o,
  input  logic [NR_SLAVES-1:0]             s_gnt_i,
  input  logic [NR_SLAVES-1:0]             s_r_valid_i,
  input  logic [NR_SLAVES*DATA_WIDTH-1:0]  s_r_rdata_i,
  input  logic [NR_SLAVES-1:0]             s_r_opc_i,
  input  logic                             err_clr_i,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt_o
);

  localparam int MW = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;
  localparam int CW = $clog2(NR_MASTERS+1);
  localparam int SW = ERR_CNT_WIDTH + CW;
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_DATA);

  logic [NR_MASTERS-1:0][IDX_WIDTH-1:0] tgt;
  logic [NR_MASTERS-1:0]                unmap;
  logic [NR_MASTERS-1:0]                err_gnt;
  logic [NR_SLAVES-1:0][NR_MASTERS-1:0] cand;
  logic [NR_SLAVES-1:0][MW-1:0]         win;

  logic [NR_MASTERS-1:0]                pend_q, pend_d;
  logic [NR_MASTERS-1:0]                err_q, err_d;
  logic [NR_MASTERS-1:0][IDX_WIDTH-1:0] sel_q, sel_d;
  logic [ERR_CNT_WIDTH-1:0]             err_cnt_q, err_cnt_d;
  logic [CW-1:0]                        inc;
  logic [SW-1:0]                        sum;

  // Address decode: rules scanned high to low so the lowest matching rule wins.
  always_comb begin
    tgt   = '0;
    unmap = '1;
    for (int m = 0; m < NR_MASTERS; m++) begin
      for (int r = NR_RULES-1; r >= 0; r--) begin
        if (m_add_i[m*ADDR_WIDTH +: ADDR_WIDTH] >= rule_start_i[r*ADDR_WIDTH +: ADDR_WIDTH] &&
            m_add_i[m*ADDR_WIDTH +: ADDR_WIDTH] <  rule_end_i[r*ADDR_WIDTH +: ADDR_WIDTH]) begin
          tgt[m]   = rule_idx_i[r*IDX_WIDTH +: IDX_WIDTH];
          unmap[m] = 1'b0;
        end
      end
      if (tgt[m] >= IDX_WIDTH'(NR_SLAVES)) unmap[m] = 1'b1;
    end
  end

  // Candidate matrix per slave; unmapped requests go to the error responder.
  always_comb begin
    cand    = '0;
    err_gnt = m_req_i & unmap;
    for (int s = 0; s < NR_SLAVES; s++)
      for (int m = 0; m < NR_MASTERS; m++)
        cand[s][m] = m_req_i[m] & ~unmap[m] & (tgt[m] == IDX_WIDTH'(s));
  end

  for (genvar gs = 0; gs < NR_SLAVES; gs++) begin : g_arb
    soc_tcdm_rr_xbar_arb #(
      .NR_MASTERS(NR_MASTERS),
      .MW        (MW)
    ) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cand_i(cand[gs]),
      .gnt_i (s_gnt_i[gs]),
      .req_o (s_req_o[gs]),
      .win_o (win[gs])
    );
  end

  // Forward winner payload to each slave and route the slave grant back.
  always_comb begin
    s_add_o   = '0;
    s_wen_o   = '0;
    s_wdata_o = '0;
    s_be_o    = '0;
    m_gnt_o   = err_gnt;
    for (int s = 0; s < NR_SLAVES; s++) begin
      for (int m = 0; m < NR_MASTERS; m++) begin
        if (s_req_o[s] && win[s] == MW'(m)) begin
          s_add_o[s*ADDR_WIDTH +: ADDR_WIDTH] = m_add_i[m*ADDR_WIDTH +: ADDR_WIDTH];
          s_wen_o[s]                          = m_wen_i[m];
          s_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = m_wdata_i[m*DATA_WIDTH +: DATA_WIDTH];
          s_be_o[s*BE_WIDTH +: BE_WIDTH]      = m_be_i[m*BE_WIDTH +: BE_WIDTH];
          if (s_gnt_i[s]) m_gnt_o[m] = 1'b1;
        end
      end
    end
  end

  // Remember where each granted access went; unmapped ones park sel at 0.
  always_comb begin
    pend_d = m_gnt_o;
    sel_d  = sel_q;
    err_d  = err_q;
    for (int m = 0; m < NR_MASTERS; m++) begin
      if (m_gnt_o[m]) begin
        err_d[m] = unmap[m];
        sel_d[m] = unmap[m] ? '0 : tgt[m];
      end
    end
  end

  // Response-tracking state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      sel_q  <= '0;
      err_q  <= '0;
    end else begin
      pend_q <= pend_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  // Response mux: error responder or the slave recorded at grant time.
  always_comb begin
    m_r_valid_o = '0;
    m_r_rdata_o = '0;
    m_r_opc_o   = '0;
    for (int m = 0; m < NR_MASTERS; m++) begin
      if (pend_q[m]) begin
        if (err_q[m]) begin
          m_r_valid_o[m]                        = 1'b1;
          m_r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = ERR_RDATA;
          m_r_opc_o[m]                          = 1'b1;
        end else begin
          for (int s = 0; s < NR_SLAVES; s++) begin
            if (sel_q[m] == IDX_WIDTH'(s)) begin
              m_r_valid_o[m]                        = s_r_valid_i[s];
              m_r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = s_r_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
              m_r_opc_o[m]                          = s_r_opc_i[s];
            end
          end
        end
      end
    end
  end

  // Saturating error counter; clear beats same-cycle increments.
  always_comb begin
    inc = '0;
    for (int m = 0; m < NR_MASTERS; m++) inc = inc + CW'(err_gnt[m]);
    sum = SW'(err_cnt_q) + SW'(inc);
    if (err_clr_i)                           err_cnt_d = '0;
    else if (sum[SW-1:ERR_CNT_WIDTH] != '0)  err_cnt_d = '1;
    else                                     err_cnt_d = sum[ERR_CNT_WIDTH-1:0];
  end

  // Error counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;

endmodule
